// File: rtl/edge_core_scheduler.sv
// Walks the edges of a job and splits each edge's features into per-core segments,
// packing segments into rounds of NUM_CORE cores and launching each round once it is full.
module edge_core_scheduler #(
  parameter int TOTAL_F    = 3703,
  parameter int NUM_CORE   = 64,
  parameter int F_PER_CORE = 32,
  parameter int EDGE_W     = 16,
  parameter int CW         = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [EDGE_W-1:0] num_edges,
  output logic              seg_valid,
  input  logic              seg_ready,
  output logic [EDGE_W-1:0] seg_edge,
  output logic [11:0]       seg_f_lo,
  output logic [11:0]       seg_f_hi,
  output logic [CW-1:0]     seg_core_lo,
  output logic [CW-1:0]     seg_core_cnt,
  output logic              seg_last,
  output logic              launch,
  output logic [CW-1:0]     launch_cores,
  input  logic              round_done,
  output logic              busy,
  output logic              done,
  output logic [15:0]       round_cnt
);

  localparam int SH = $clog2(F_PER_CORE);

  typedef enum logic [1:0] {IDLE, ALLOC, LAUNCH, WAIT} state_t;

  state_t            state_reg;
  logic [EDGE_W-1:0] num_edges_reg;
  logic [EDGE_W-1:0] edge_idx_reg;
  logic [11:0]       f_pos_reg;
  logic [CW-1:0]     core_pos_reg;
  logic [15:0]       round_cnt_reg;
  logic              done_reg;

  // Segment descriptor depends only on registered state, so it holds steady under back-pressure.
  logic [11:0]   rem_f;
  logic [12:0]   need;
  logic [CW-1:0] free;
  logic          fits;
  logic [11:0]   span;
  logic [11:0]   f_hi_split;
  logic [11:0]   seg_hi;
  logic [CW-1:0] seg_cnt;
  logic [CW-1:0] core_after;
  logic          last_edge;
  logic          alloc;

  assign rem_f      = 12'(TOTAL_F) - f_pos_reg;
  assign need       = (13'(rem_f) + 13'(F_PER_CORE - 1)) >> SH;
  assign free       = CW'(NUM_CORE) - core_pos_reg;
  assign fits       = need <= 13'(free);
  assign span       = 12'(free) << SH;
  assign f_hi_split = f_pos_reg + span;
  assign seg_hi     = fits ? 12'(TOTAL_F) : f_hi_split;
  assign seg_cnt    = fits ? need[CW-1:0] : free;
  assign core_after = core_pos_reg + seg_cnt;
  assign last_edge  = (edge_idx_reg == num_edges_reg - EDGE_W'(1));
  assign alloc      = (state_reg == ALLOC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      num_edges_reg <= '0;
      edge_idx_reg  <= '0;
      f_pos_reg     <= '0;
      core_pos_reg  <= '0;
      round_cnt_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            num_edges_reg <= num_edges;
            edge_idx_reg  <= '0;
            f_pos_reg     <= '0;
            core_pos_reg  <= '0;
            round_cnt_reg <= '0;
            if (num_edges == '0) done_reg <= 1'b1;
            else                 state_reg <= ALLOC;
          end
        end
        ALLOC: begin
          if (seg_ready) begin
            core_pos_reg <= core_after;
            if (fits) begin
              edge_idx_reg <= edge_idx_reg + EDGE_W'(1);
              f_pos_reg    <= '0;
            end else begin
              f_pos_reg <= f_hi_split;
            end
            if (core_after == CW'(NUM_CORE) || (fits && last_edge))
              state_reg <= LAUNCH;
          end
        end
        LAUNCH: state_reg <= WAIT;
        WAIT: begin
          if (round_done) begin
            round_cnt_reg <= round_cnt_reg + 16'd1;
            core_pos_reg  <= '0;
            // edge_idx has already advanced past the final edge when the job is finished
            if (edge_idx_reg == num_edges_reg) begin
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end else begin
              state_reg <= ALLOC;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign seg_valid    = alloc;
  assign seg_edge     = alloc ? edge_idx_reg : '0;
  assign seg_f_lo     = alloc ? f_pos_reg : '0;
  assign seg_f_hi     = alloc ? seg_hi : '0;
  assign seg_core_lo  = alloc ? core_pos_reg : '0;
  assign seg_core_cnt = alloc ? seg_cnt : '0;
  assign seg_last     = alloc & fits;
  assign launch       = (state_reg == LAUNCH);
  assign launch_cores = launch ? core_pos_reg : '0;
  assign busy         = (state_reg != IDLE);
  assign done         = done_reg;
  assign round_cnt    = round_cnt_reg;

endmodule

// File: tb/tb_edge_core_scheduler.sv
// Randomized bench for edge_core_scheduler: expected segments and launches come from a
// feature/core packing model; stalls, stray inputs and mid-job reset are exercised.
module tb_edge_core_scheduler;
  localparam int T   = 3703;
  localparam int NC  = 64;
  localparam int FPC = 32;
  localparam int EW  = 16;
  localparam int CW  = 7;

  logic          clk = 1'b0;
  logic          rst, start, seg_ready, round_done;
  logic [EW-1:0] num_edges;
  logic          seg_valid, seg_last, launch, busy, done;
  logic [EW-1:0] seg_edge;
  logic [11:0]   seg_f_lo, seg_f_hi;
  logic [CW-1:0] seg_core_lo, seg_core_cnt, launch_cores;
  logic [15:0]   round_cnt;

  edge_core_scheduler #(.TOTAL_F(T), .NUM_CORE(NC), .F_PER_CORE(FPC), .EDGE_W(EW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_edges(num_edges),
    .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_edge(seg_edge),
    .seg_f_lo(seg_f_lo), .seg_f_hi(seg_f_hi), .seg_core_lo(seg_core_lo),
    .seg_core_cnt(seg_core_cnt), .seg_last(seg_last), .launch(launch),
    .launch_cores(launch_cores), .round_done(round_done), .busy(busy),
    .done(done), .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int e, lo, hi, clo, cnt;
    bit last;
  } seg_t;

  seg_t exp_q[$];
  int   exp_l[$];
  int   obs_l[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Packs each edge's features into chunks of whole cores, closing a round whenever the pool fills.
  function automatic void build_model(input int n);
    int cp, f, free_c, need_c;
    exp_q.delete();
    exp_l.delete();
    cp = 0;
    for (int e = 0; e < n; e++) begin
      f = 0;
      while (f < T) begin
        free_c = NC - cp;
        need_c = (T - f + FPC - 1) / FPC;
        if (need_c <= free_c) begin
          exp_q.push_back('{e, f, T, cp, need_c, 1'b1});
          cp += need_c;
          f = T;
        end else begin
          exp_q.push_back('{e, f, f + free_c * FPC, cp, free_c, 1'b0});
          f += free_c * FPC;
          cp = NC;
        end
        if (cp == NC) begin
          exp_l.push_back(NC);
          cp = 0;
        end
      end
    end
    if (cp > 0) exp_l.push_back(cp);
  endfunction

  task automatic run_job(input int n, input bit stall, input bit abn, input string tag);
    int   stall_cnt, wait_cnt, launches, rounds;
    bit   in_wait, finished;
    seg_t h;
    build_model(n);
    rounds = exp_l.size();
    obs_l.delete();
    @(negedge clk);
    num_edges = EW'(n);
    start = 1'b1;
    @(negedge clk);
    stall_cnt = stall ? $urandom_range(0, 5) : 0;
    wait_cnt = 0; in_wait = 0; launches = 0; finished = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      start = 1'b0;
      round_done = 1'b0;
      num_edges = EW'(n);
      if (done) begin
        finished = 1;
        vectors++;
        if (round_cnt !== 16'(rounds) || busy !== 1'b0 || exp_q.size() != 0 || exp_l.size() != 0) begin
          miscompares++;
          $display("FAIL %s job_end: round_cnt=%0d busy=%0d segs_left=%0d launches_left=%0d, required round_cnt=%0d busy=0 none left",
                   tag, round_cnt, busy, exp_q.size(), exp_l.size(), rounds);
        end
        break;
      end
      if (seg_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL %s extra_seg: got e%0d [%0d,%0d) c%0d n%0d, required no segment",
                   tag, seg_edge, seg_f_lo, seg_f_hi, seg_core_lo, seg_core_cnt);
          seg_ready = 1'b1;
        end else begin
          h = exp_q[0];
          if (seg_edge !== EW'(h.e) || seg_f_lo !== 12'(h.lo) || seg_f_hi !== 12'(h.hi) ||
              seg_core_lo !== CW'(h.clo) || seg_core_cnt !== CW'(h.cnt) || seg_last !== h.last) begin
            miscompares++;
            $display("FAIL %s seg: got e%0d [%0d,%0d) c%0d n%0d last%0d, required e%0d [%0d,%0d) c%0d n%0d last%0d",
                     tag, seg_edge, seg_f_lo, seg_f_hi, seg_core_lo, seg_core_cnt, seg_last,
                     h.e, h.lo, h.hi, h.clo, h.cnt, h.last);
          end
          if (stall_cnt > 0) begin
            seg_ready = 1'b0;
            stall_cnt--;
          end else begin
            seg_ready = 1'b1;
            void'(exp_q.pop_front());
            stall_cnt = stall ? $urandom_range(0, 5) : 0;
          end
        end
        if (abn && $urandom_range(0, 2) == 0) round_done = 1'b1;
      end else begin
        seg_ready = 1'($urandom_range(0, 1));
      end
      if (launch) begin
        obs_l.push_back(int'(launch_cores));
        vectors++;
        if (exp_l.size() == 0) begin
          miscompares++;
          $display("FAIL %s extra_launch: got launch_cores=%0d, required no launch", tag, launch_cores);
        end else if (launch_cores !== CW'(exp_l[0])) begin
          miscompares++;
          $display("FAIL %s launch_cores: got %0d, required %0d", tag, launch_cores, exp_l[0]);
        end
        if (exp_l.size() != 0) void'(exp_l.pop_front());
        vectors++;
        if (round_cnt !== 16'(launches)) begin
          miscompares++;
          $display("FAIL %s round_cnt_at_launch: got %0d, required %0d", tag, round_cnt, launches);
        end
        launches++;
        in_wait = 1;
        wait_cnt = $urandom_range(1, 4);
      end else if (in_wait) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          round_done = 1'b1;
          in_wait = 0;
        end else if (abn) begin
          start = 1'b1;
          num_edges = EW'(7);
        end
      end
      @(negedge clk);
    end
    if (!finished) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: got no done, required done pulse", tag);
    end
    seg_ready = 1'b0;
    round_done = 1'b0;
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_width: got done=%0d, required 0", tag, done);
    end
    $display("job %s: n=%0d rounds=%0d launches_seen=%0d", tag, n, rounds, obs_l.size());
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({seg_valid, seg_edge, seg_f_lo, seg_f_hi, seg_core_lo, seg_core_cnt, seg_last,
         launch, launch_cores, busy, done, round_cnt} !== '0) begin
      miscompares++;
      $display("FAIL %s outputs: got valid=%0d edge=%0d lo=%0d hi=%0d clo=%0d cnt=%0d launch=%0d lc=%0d busy=%0d done=%0d rc=%0d, required all 0",
               tag, seg_valid, seg_edge, seg_f_lo, seg_f_hi, seg_core_lo, seg_core_cnt,
               launch, launch_cores, busy, done, round_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");
  endtask

  task automatic test_single();
    run_job(1, 0, 0, "single");
    vectors++;
    if (obs_l.size() != 2 || obs_l[0] != 64 || obs_l[1] != 52) begin
      miscompares++;
      $display("FAIL single launch_list: got %0d launches first=%0d, required 2 launches 64,52",
               obs_l.size(), (obs_l.size() > 0) ? obs_l[0] : -1);
    end
  endtask

  task automatic test_two();
    run_job(2, 0, 0, "two");
    vectors++;
    if (obs_l.size() != 4 || obs_l[3] != 40) begin
      miscompares++;
      $display("FAIL two launch_list: got %0d launches, required 4 ending in 40", obs_l.size());
    end
  endtask

  task automatic test_stall();
    run_job(3, 1, 0, "stall");
  endtask

  task automatic test_zero_edges();
    @(negedge clk);
    num_edges = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || seg_valid !== 1'b0 || launch !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_edges: got done=%0d busy=%0d valid=%0d launch=%0d, required 1 0 0 0",
               done, busy, seg_valid, launch);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || seg_valid !== 1'b0 || launch !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_edges_after: got done=%0d busy=%0d valid=%0d launch=%0d, required all 0",
                 done, busy, seg_valid, launch);
      end
    end
    $display("job zero: n=0 done pulse checked");
  endtask

  task automatic test_abnormal();
    run_job(2, 1, 1, "abnormal");
  endtask

  task automatic test_rst_in_wait();
    bit seen;
    seen = 0;
    @(negedge clk);
    num_edges = EW'(3);
    start = 1'b1;
    seg_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (launch) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rst_in_wait launch_timeout: got no launch, required launch");
    end
    seg_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst_in_wait");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_in_wait_idle: got done=%0d busy=%0d, required 0 0", done, busy);
      end
    end
    $display("job rst_in_wait: abandoned after first launch");
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 3; j++) run_job($urandom_range(1, 5), 1, 0, "b2b");
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    seg_ready = 1'b0;
    round_done = 1'b0;
    num_edges = '0;
    test_reset();
    test_single();
    test_two();
    test_stall();
    test_zero_edges();
    test_abnormal();
    test_rst_in_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
